// File: rtl/draw_car_pkg.sv
// Shared VGA bus layout, 800x600 timing constants and car sprite artwork.
package draw_car_pkg;

    localparam int unsigned H_ACTIVE            = 800;
    localparam int unsigned V_ACTIVE            = 600;
    localparam int unsigned H_TOTAL             = 1056;
    localparam int unsigned V_TOTAL             = 628;
    localparam int unsigned COUNT_W             = 11;
    localparam int unsigned RGB_W               = 12;
    localparam int unsigned SPRITE_SIZE_DEFAULT = 32;
    localparam int unsigned ROM_AW              = 10;
    localparam logic [RGB_W-1:0] TRANSPARENT_DEFAULT = 12'hF0F;

    typedef struct packed {
        logic [COUNT_W-1:0] hcount;
        logic [COUNT_W-1:0] vcount;
        logic               hsync;
        logic               vsync;
        logic               hblnk;
        logic               vblnk;
        logic [RGB_W-1:0]   rgb;
    } vga_bus_t;

    localparam int unsigned VGA_BUS_SIZE = $bits(vga_bus_t);

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    // Car artwork: checkerboard of transparent cells and position-tinted pixels.
    function automatic logic [RGB_W-1:0] car_pixel(input logic [ROM_AW-1:0] addr);
        logic [4:0]       r;
        logic [4:0]       c;
        logic [RGB_W-1:0] pix;
        r = addr[9:5];
        c = addr[4:0];
        if ((r[0] ^ c[0]) == 1'b1) begin
            pix = TRANSPARENT_DEFAULT;
        end else begin
            pix = 12'h0F0 ^ {r[3:0], c[3:0], r[4], c[4], 2'b00};
        end
        return pix;
    endfunction

endpackage

// File: rtl/car_rom.sv
// Synchronous 1024x12 car sprite ROM with one-cycle read latency.
module car_rom
    import draw_car_pkg::*;
(
    input  logic              clk,
    input  logic [ROM_AW-1:0] addr,
    output logic [RGB_W-1:0]  rgb
);

    always_ff @(posedge clk) begin
        rgb <= car_pixel(addr);
    end

endmodule

// File: rtl/draw_car.sv
// Car sprite overlay on the VGA bus: frame-latched position and orientation,
// transparent-colour keying, three-cycle latency on every bus field.
module draw_car
    import draw_car_pkg::*;
#(
    parameter int unsigned      SPRITE_SIZE = SPRITE_SIZE_DEFAULT,
    parameter logic [RGB_W-1:0] TRANSPARENT = TRANSPARENT_DEFAULT
) (
    input  logic               pclk,
    input  logic               rst,
    input  vga_bus_t           vga_in,
    output vga_bus_t           vga_out,
    input  logic [COUNT_W-1:0] xpos,
    input  logic [COUNT_W-1:0] ypos,
    input  logic [1:0]         dir,
    input  logic               enable
);

    localparam int unsigned SW = $clog2(SPRITE_SIZE);

    logic [COUNT_W-1:0] xs;
    logic [COUNT_W-1:0] ys;
    dir_t               dir_s;
    logic               enable_s;
    logic               vblnk_prev;

    logic [COUNT_W-1:0] u;
    logic [COUNT_W-1:0] v;
    logic [SW-1:0]      row;
    logic [SW-1:0]      col;
    logic               inside_c;

    logic [2*SW-1:0]    addr_q;
    logic               inside_d1;
    logic               inside_d2;
    vga_bus_t           bus_d1;
    vga_bus_t           bus_d2;
    logic [RGB_W-1:0]   rom_rgb;
    vga_bus_t           out_c;

    // Shadow registers only move on the vblnk rising edge, so a frame never tears.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            xs         <= '0;
            ys         <= '0;
            dir_s      <= DIR_UP;
            enable_s   <= 1'b0;
            vblnk_prev <= 1'b0;
        end else begin
            vblnk_prev <= vga_in.vblnk;
            if (vga_in.vblnk && !vblnk_prev) begin
                xs       <= xpos;
                ys       <= ypos;
                dir_s    <= dir_t'(dir);
                enable_s <= enable;
            end
        end
    end

    // Local coordinates wrap, so pixels left of or above the sprite fail the range test.
    always_comb begin
        u        = vga_in.hcount - xs;
        v        = vga_in.vcount - ys;
        inside_c = enable_s & ~vga_in.hblnk & ~vga_in.vblnk
                 & (u < COUNT_W'(SPRITE_SIZE)) & (v < COUNT_W'(SPRITE_SIZE));
        row      = v[SW-1:0];
        col      = u[SW-1:0];
        case (dir_s)
            DIR_UP: begin
                row = v[SW-1:0];
                col = u[SW-1:0];
            end
            DIR_RIGHT: begin
                row = u[SW-1:0];
                col = ~v[SW-1:0];
            end
            DIR_DOWN: begin
                row = ~v[SW-1:0];
                col = ~u[SW-1:0];
            end
            DIR_LEFT: begin
                row = ~u[SW-1:0];
                col = v[SW-1:0];
            end
            default: begin
                row = v[SW-1:0];
                col = u[SW-1:0];
            end
        endcase
    end

    car_rom u_car_rom (
        .clk  (pclk),
        .addr (addr_q),
        .rgb  (rom_rgb)
    );

    // Blanking forces black; opaque sprite pixels replace the delayed background.
    always_comb begin
        out_c = bus_d2;
        if (bus_d2.hblnk || bus_d2.vblnk) begin
            out_c.rgb = '0;
        end else if (inside_d2 && (rom_rgb != TRANSPARENT)) begin
            out_c.rgb = rom_rgb;
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            addr_q    <= '0;
            inside_d1 <= 1'b0;
            inside_d2 <= 1'b0;
            bus_d1    <= '0;
            bus_d2    <= '0;
            vga_out   <= '0;
        end else begin
            addr_q    <= {row, col};
            inside_d1 <= inside_c;
            bus_d1    <= vga_in;
            inside_d2 <= inside_d1;
            bus_d2    <= bus_d1;
            vga_out   <= out_c;
        end
    end

endmodule

// File: tb/tb_draw_car.sv
// Randomized scoreboard bench for draw_car against a per-pixel reference model.
module tb_draw_car;
    import draw_car_pkg::*;

    logic        pclk = 1'b0;
    logic        rst  = 1'b0;
    vga_bus_t    vin  = '0;
    vga_bus_t    vout;
    logic [10:0] xpos = '0;
    logic [10:0] ypos = '0;
    logic [1:0]  dir  = '0;
    logic        enable = 1'b0;

    typedef struct {
        int       due;
        vga_bus_t exp;
    } exp_t;

    exp_t sbq[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    // Reference model state: what the design should have latched so far.
    int m_xs, m_ys, m_dir, m_en, m_prev;
    int chg_v = -1;
    int chg_x = 0;

    draw_car dut (
        .pclk    (pclk),
        .rst     (rst),
        .vga_in  (vin),
        .vga_out (vout),
        .xpos    (xpos),
        .ypos    (ypos),
        .dir     (dir),
        .enable  (enable)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] ref_pix(input int r, input int c);
        if ((r + c) % 2 == 1) return 12'hF0F;
        return 12'(((r % 16) * 256 + (c % 16) * 16 + (r / 16) * 8 + (c / 16) * 4) ^ 'h0F0);
    endfunction

    task automatic model_reset();
        m_xs = 0; m_ys = 0; m_dir = 0; m_en = 0; m_prev = 0;
    endtask

    task automatic drive_pixel(input int h, input int v);
        exp_t e;
        int   dx, dy, r, c;
        logic [11:0] p;
        @(negedge pclk);
        vin.hcount = 11'(h);
        vin.vcount = 11'(v);
        vin.hsync  = (h >= 840 && h < 968);
        vin.vsync  = (v >= 601 && v < 605);
        vin.hblnk  = (h >= 800);
        vin.vblnk  = (v >= 600);
        vin.rgb    = 12'($urandom);
        e.exp = vin;
        e.due = cyc + 3;
        if (h >= 800 || v >= 600) begin
            e.exp.rgb = 12'h000;
        end else begin
            dx = (h - m_xs) & 2047;
            dy = (v - m_ys) & 2047;
            if (m_en != 0 && dx < 32 && dy < 32) begin
                case (m_dir)
                    0: begin r = dy;      c = dx;      end
                    1: begin r = dx;      c = 31 - dy; end
                    2: begin r = 31 - dy; c = 31 - dx; end
                    default: begin r = 31 - dx; c = dy; end
                endcase
                p = ref_pix(r, c);
                if (p != 12'hF0F) e.exp.rgb = p;
            end
        end
        sbq.push_back(e);
        if (v >= 600 && m_prev == 0) begin
            m_xs = int'(xpos); m_ys = int'(ypos); m_dir = int'(dir); m_en = int'(enable);
        end
        m_prev = (v >= 600) ? 1 : 0;
    endtask

    task automatic do_hwin(input int v, input int wx);
        int lo, hi;
        lo = (wx - 3 < 0) ? 0 : wx - 3;
        hi = (wx + 35 > 1055) ? 1055 : wx + 35;
        for (int h = lo; h <= hi; h++) drive_pixel(h, v);
    endtask

    // Active lines around the sprite window, then vertical blanking (latch point).
    task automatic run_frame(input int wy, input int wx0, input int wx1);
        int lo, hi;
        lo = (wy - 2 < 0) ? 0 : wy - 2;
        hi = (wy + 33 > 627) ? 627 : wy + 33;
        for (int v = lo; v <= hi; v++) begin
            if (v == chg_v) xpos = 11'(chg_x);
            do_hwin(v, wx0);
            if (wx1 >= 0) do_hwin(v, wx1);
            drive_pixel(799, v);
            drive_pixel(800, v);
            drive_pixel(1055, v);
        end
        if (hi < 600) for (int h = 0; h < 4; h++) drive_pixel(h, 600);
        for (int h = 0; h < 2; h++) drive_pixel(h, 627);
    endtask

    task automatic do_reset();
        exp_t z;
        @(negedge pclk);
        rst = 1'b1;
        sbq.delete();
        model_reset();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge pclk);
            #1;
            checks++;
            if (vout !== '0) begin
                errors++;
                $display("FAIL reset_zero cycle %0d: got %h want 0", i, vout);
            end
        end
        @(negedge pclk);
        rst = 1'b0;
        z.exp = '0;
        z.due = cyc + 1;
        sbq.push_back(z);
        z.due = cyc + 2;
        sbq.push_back(z);
    endtask

    // Monitor: compare each output cycle against the oldest pending expectation.
    always @(posedge pclk) begin
        exp_t e;
        #1;
        if (!rst && sbq.size() > 0 && sbq[0].due <= cyc) begin
            e = sbq.pop_front();
            checks++;
            if (e.due != cyc || vout !== e.exp) begin
                errors++;
                $display("FAIL vga_out h=%0d v=%0d at cycle %0d (due %0d): got %h want %h",
                         e.exp.hcount, e.exp.vcount, cyc, e.due, vout, e.exp);
            end
        end
    end

    initial begin
        model_reset();
        do_reset();

        // Pass-through with the sprite disabled.
        enable = 1'b0; xpos = 11'd100; ypos = 11'd200; dir = 2'd0;
        run_frame(200, 100, -1);
        run_frame(200, 100, -1);

        // Drawing and transparency, then each orientation in turn.
        enable = 1'b1;
        for (int d = 0; d < 4; d++) begin
            dir = 2'(d);
            run_frame(200, 100, -1);
        end
        run_frame(200, 100, -1);

        // Clipping at the bottom-right corner of the active area.
        xpos = 11'd790; ypos = 11'd590; dir = 2'd2;
        run_frame(590, 790, -1);
        run_frame(590, 790, -1);

        // Mid-frame position change only shows up next frame.
        xpos = 11'd100; ypos = 11'd290; dir = 2'd0;
        run_frame(290, 100, 300);
        chg_v = 300; chg_x = 300;
        run_frame(290, 100, 300);
        chg_v = -1;
        run_frame(290, 100, 300);

        // Random positions, orientations and mid-frame changes.
        for (int f = 0; f < 6; f++) begin
            int ox;
            ox     = int'(xpos);
            xpos   = 11'($urandom_range(0, 799));
            ypos   = 11'($urandom_range(0, 599));
            dir    = 2'($urandom);
            enable = ($urandom_range(0, 4) != 0);
            chg_v  = int'(ypos) + int'($urandom_range(0, 31));
            chg_x  = int'($urandom_range(0, 799));
            run_frame(int'(ypos), int'(xpos), ox);
        end
        chg_v = -1;

        // Reset mid-line: sprite stays off until the next vblnk edge.
        xpos = 11'd100; ypos = 11'd200; dir = 2'd1; enable = 1'b1;
        run_frame(200, 100, -1);
        for (int h = 90; h < 100; h++) drive_pixel(h, 205);
        do_reset();
        for (int h = 100; h < 140; h++) drive_pixel(h, 205);
        run_frame(200, 100, -1);
        run_frame(200, 100, -1);

        for (int i = 0; i < 20 && sbq.size() > 0; i++) @(posedge pclk);
        #2;
        if (sbq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations pending, want 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
